delay_capture: RTL
==================

DELAY_CAPTURE -- requirements
Module: delay_capture

Interface
REQ-001 Parameter TS_W, default 16: width of free-running timestamp counter.
REQ-002 Parameter DLY_W, default 8: width of measured delay; MAX_WAIT = 2^DLY_W-1.
REQ-003 Parameter DEPTH, default 8: record FIFO depth, power of two, >= 2.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  high = capture enabled; low = return to IDLE after any in-flight measurement completes.
REQ-007 stim_a  input  1  stimulus bit a driven into the device under measurement.
REQ-008 stim_b  input  1  stimulus bit b driven into the device under measurement.
REQ-009 dut_c  input  1  output c of the device under measurement, sampled synchronously.
REQ-010 rec_valid  output  1  FIFO head record available.
REQ-011 rec_ready  input  1  consumer accepts head record when rec_valid & rec_ready.
REQ-012 rec_data  output  2+DLY_W+TS_W  record {timeout, c_new, delay[DLY_W-1:0], t_stim[TS_W-1:0]}, MSB first.
REQ-013 busy  output  1  high in ARMED or MEASURE.
REQ-014 overflow  output  1  sticky: a record was dropped due to full FIFO.

Function
REQ-015 Timestamp counter ts SHALL increment every cycle from 0, wrapping modulo 2^TS_W, independent of en.
REQ-016 Register s_prev SHALL hold {stim_a,stim_b} from the previous edge, updated every cycle.
REQ-017 FSM states SHALL be IDLE, ARMED, MEASURE.
REQ-018 IDLE -> ARMED on an edge where en=1; ARMED -> IDLE on an edge where en=0.
REQ-019 Stimulus change at edge k: in ARMED, {stim_a,stim_b} != s_prev SHALL latch t_stim=ts, c_ref=dut_c, cnt=0, and enter MEASURE.
REQ-020 In MEASURE, each edge SHALL increment cnt; stimulus changes during MEASURE SHALL be ignored.
REQ-021 Output change at edge m: dut_c != c_ref SHALL push record {0, dut_c, m-k, t_stim}; minimum delay 1.
REQ-022 Timeout: if cnt reaches MAX_WAIT with no output change, SHALL push {1, c_ref, MAX_WAIT, t_stim}.
REQ-023 After a push, FSM SHALL go to ARMED if en=1, else IDLE; en falling mid-MEASURE SHALL NOT abort measurement.
REQ-024 Stimulus change and output change on the same edge k SHALL be treated as stimulus change only (c_ref takes new dut_c).
REQ-025 Record FIFO SHALL be first-word-fall-through; rec_data valid whenever rec_valid=1, stable until popped.
REQ-026 Push visible at rec_valid the cycle after the push edge.
REQ-027 Full FIFO with push and no pop SHALL drop the new record and set overflow.
REQ-028 Full FIFO with simultaneous push and pop SHALL accept both; no overflow.
REQ-029 Empty FIFO: rec_valid=0; rec_ready ignored; rec_data don't-care.
REQ-030 Pointers SHALL wrap modulo DEPTH; occupancy counter 0..DEPTH.
REQ-031 busy SHALL be combinational from state (ARMED or MEASURE).

Reset
REQ-032 rst_n low SHALL asynchronously force: state IDLE, ts=0, s_prev=0, cnt=0, t_stim=0, c_ref=0, FIFO empty, rec_valid=0, overflow=0, busy=0.
REQ-033 rst_n low mid-MEASURE SHALL discard the measurement; no record produced.
REQ-034 Reset release SHALL take effect synchronously on first rising edge with rst_n=1; overflow clears only by reset.

Verification
REQ-035 Basic: en=1, stim 00->10 at edge 20, dut_c 0->1 at edge 23 -> one record {0,1,3,t_stim=20}, rec_valid high next cycle.
REQ-036 Timeout: DLY_W=8, stim change, dut_c held -> record {1,c_ref,255,t_stim}; FSM back to ARMED.
REQ-037 Overflow: DEPTH=8, rec_ready=0, 9 measurements -> 8 records held, overflow=1, ninth dropped; draining yields records in order.
REQ-038 Full with pop: FIFO full, push and pop same edge -> count stays 8, overflow stays 0.
REQ-039 Mid-measure events: second stim change during MEASURE -> ignored, single record; en low mid-MEASURE -> record still pushed, then IDLE.
REQ-040 Reset mid-MEASURE: assert rst_n low asynchronously -> all outputs zero immediately, no record after release; ts wrap 0xFFFF->0x0000 reflected in t_stim.

Source files
------------

// File: rtl/delay_capture.sv
// Measures the latency from a stimulus change to the first output change of a device under test.
// Each result is queued as a timestamped record in a first-word-fall-through FIFO.
module delay_capture #(
    parameter int TS_W  = 16,
    parameter int DLY_W = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      stim_a,
    input  logic                      stim_b,
    input  logic                      dut_c,
    output logic                      rec_valid,
    input  logic                      rec_ready,
    output logic [2+DLY_W+TS_W-1:0]   rec_data,
    output logic                      busy,
    output logic                      overflow
);

    localparam int REC_W = 2 + DLY_W + TS_W;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [DLY_W-1:0] MAX_WAIT = {DLY_W{1'b1}};
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [TS_W-1:0]     ts_r;
    logic [1:0]          s_prev_r;
    logic [DLY_W-1:0]    cnt_r;
    logic [DLY_W-1:0]    cnt_inc_s;
    logic [TS_W-1:0]     t_stim_r;
    logic                c_ref_r;
    logic                latch_s;
    logic                push_s;
    logic [REC_W-1:0]    rec_in_s;

    logic [REC_W-1:0]    mem_r [DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [AW:0]         count_r;
    logic                full_s;
    logic                pop_s;
    logic                wr_s;

    assign cnt_inc_s = cnt_r + {{(DLY_W-1){1'b0}}, 1'b1};

    // Next-state and record-generation logic; an output change wins over the timeout on the last count.
    always_comb begin
        state_s  = state_r;
        latch_s  = 1'b0;
        push_s   = 1'b0;
        rec_in_s = {REC_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_s = ARMED;
                end else begin
                    state_s = IDLE;
                end
            end
            ARMED: begin
                if (!en) begin
                    state_s = IDLE;
                end else if ({stim_a, stim_b} != s_prev_r) begin
                    latch_s = 1'b1;
                    state_s = MEASURE;
                end else begin
                    state_s = ARMED;
                end
            end
            MEASURE: begin
                if (dut_c != c_ref_r) begin
                    push_s   = 1'b1;
                    rec_in_s = {1'b0, dut_c, cnt_inc_s, t_stim_r};
                    state_s  = en ? ARMED : IDLE;
                end else if (cnt_inc_s == MAX_WAIT) begin
                    push_s   = 1'b1;
                    rec_in_s = {1'b1, c_ref_r, MAX_WAIT, t_stim_r};
                    state_s  = en ? ARMED : IDLE;
                end else begin
                    state_s  = MEASURE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Timestamp, previous stimulus and measurement context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r     <= {TS_W{1'b0}};
            s_prev_r <= 2'b00;
            cnt_r    <= {DLY_W{1'b0}};
            t_stim_r <= {TS_W{1'b0}};
            c_ref_r  <= 1'b0;
        end else begin
            ts_r     <= ts_r + {{(TS_W-1){1'b0}}, 1'b1};
            s_prev_r <= {stim_a, stim_b};
            if (latch_s) begin
                t_stim_r <= ts_r;
                c_ref_r  <= dut_c;
                cnt_r    <= {DLY_W{1'b0}};
            end else if (state_r == MEASURE) begin
                cnt_r    <= cnt_inc_s;
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped on the same edge.
    assign full_s = (count_r == FULL_CNT);
    assign pop_s  = (count_r != {(AW+1){1'b0}}) && rec_ready;
    assign wr_s   = push_s && (!full_s || pop_s);

    // Record storage; contents are only observed while occupied, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= rec_in_s;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            overflow <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
            if (push_s && full_s && !pop_s) begin
                overflow <= 1'b1;
            end
        end
    end

    assign rec_valid = (count_r != {(AW+1){1'b0}});
    assign rec_data  = rec_valid ? mem_r[rd_ptr_r] : {REC_W{1'b0}};
    assign busy      = (state_r == ARMED) || (state_r == MEASURE);

endmodule
